// File: rtl/macro_ctrl.sv
// ---------------------------------------------------------------------------
// macro_ctrl
//
// Command sequencer for a compute-in-memory macro. It accepts one command at
// a time and translates it into macro strobes:
//   LOAD    : streams ROWS weight rows from the wt_* channel into the macro.
//   READ    : reads one row back and returns it zero-extended on rsp_*.
//   COMPUTE : registers the activations, waits CMP_LAT cycles and returns
//             the macro's PSUM on rsp_*.
//   op 11   : reserved; it is accepted and silently dropped.
//
// Ports
//   clk, rst                 : clock; synchronous active-high reset
//   cmd_valid/cmd_ready      : command channel (cmd_op, cmd_addr, act_data)
//   wt_valid/wt_ready        : weight-row channel (wt_data, 4b x 8)
//   rsp_valid/rsp_ready      : response channel (rsp_data, 14b x 8 or row)
//   load_done                : one-cycle pulse after the last LOAD beat
//   busy                     : controller is not in IDLE
//   STDW, STDR, STD_A        : macro write strobe, read strobe, row address
//   weight_in, act_in        : data driven into the macro
//   weight_out, PSUM         : data returned by the macro
//   dbg_state                : current FSM state (IDLE=0 LOAD=1 READ=2
//                              CMP=3 RSP=4), for observation only
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clock edge where both valid and ready are high. A valid source keeps its
// payload stable until that edge; ready never depends on valid of the same
// channel (wt_ready and cmd_ready depend only on state and rst).
//
// While rst is high every output is forced to zero, independently of the
// state still held in the flops, so nothing leaks out during the reset cycle.
// Macro contents are never cleared.
// ---------------------------------------------------------------------------
module macro_ctrl #(
  parameter int ROWS    = 64,  // rows per LOAD, 1..64 (STD_A is 6 bits)
  parameter int CMP_LAT = 1    // CMP cycles before PSUM capture, 1..15
) (
  input  logic         clk,
  input  logic         rst,
  // command channel
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [5:0]   cmd_addr,
  input  logic [255:0] act_data,
  // weight channel
  input  logic         wt_valid,
  output logic         wt_ready,
  input  logic [31:0]  wt_data,
  // response channel
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [111:0] rsp_data,
  // status
  output logic         load_done,
  output logic         busy,
  // macro interface
  output logic         STDW,
  output logic         STDR,
  output logic [5:0]   STD_A,
  output logic [31:0]  weight_in,
  output logic [255:0] act_in,
  input  logic [31:0]  weight_out,
  input  logic [111:0] PSUM,
  // debug
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_READ = 3'd2,
    ST_CMP  = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;

  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [3:0] LAT_LAST = 4'(CMP_LAT - 1);

  state_t         state_q, state_d;
  logic [5:0]     row_q, row_d;         // next weight row to write
  logic [5:0]     addr_q, addr_d;       // row latched for READ
  logic [3:0]     lat_q, lat_d;         // cycles already spent in CMP
  logic [255:0]   act_q, act_d;         // activations held for the macro
  logic [111:0]   rsp_q, rsp_d;         // response payload
  logic           load_done_q, load_done_d;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    addr_d      = addr_q;
    lat_d       = lat_q;
    act_d       = act_q;
    rsp_d       = rsp_q;
    load_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone is the accept.
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LOAD: begin
              row_d   = '0;
              state_d = ST_LOAD;
            end
            OP_READ: begin
              addr_d  = cmd_addr;
              state_d = ST_READ;
            end
            OP_COMPUTE: begin
              act_d   = act_data;
              lat_d   = '0;
              state_d = ST_CMP;
            end
            default: begin
              // Reserved op: consumed with no effect, stay in IDLE.
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      ST_LOAD: begin
        // wt_ready is high in LOAD, so every wt_valid cycle is a beat.
        if (wt_valid) begin
          if (row_q == LAST_ROW) begin
            row_d       = '0;
            load_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            row_d = row_q + 6'd1;
          end
        end
      end

      ST_READ: begin
        // The macro presents the addressed row during the single READ cycle.
        rsp_d   = {80'b0, weight_out};
        state_d = ST_RSP;
      end

      ST_CMP: begin
        if (lat_q == LAT_LAST) begin
          rsp_d   = PSUM;
          state_d = ST_RSP;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      addr_q      <= '0;
      lat_q       <= '0;
      act_q       <= '0;
      rsp_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      lat_q       <= lat_d;
      act_q       <= act_d;
      rsp_q       <= rsp_d;
      load_done_q <= load_done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state, all forced low during reset.
  // -------------------------------------------------------------------------
  logic in_load;
  logic in_read;

  assign in_load = !rst && (state_q == ST_LOAD);
  assign in_read = !rst && (state_q == ST_READ);

  assign cmd_ready = !rst && (state_q == ST_IDLE);
  assign wt_ready  = in_load;
  // Write strobe follows wt_valid directly so a stalled beat never writes.
  assign STDW      = in_load && wt_valid;
  // STDR only in READ, STDW only in LOAD: the two can never overlap.
  assign STDR      = in_read;
  assign STD_A     = in_load ? row_q :
                     in_read ? addr_q : 6'd0;
  assign weight_in = in_load ? wt_data : 32'd0;
  assign act_in    = rst ? 256'd0 : act_q;
  assign rsp_valid = !rst && (state_q == ST_RSP);
  assign rsp_data  = rst ? 112'd0 : rsp_q;
  assign load_done = !rst && load_done_q;
  assign busy      = !rst && (state_q != ST_IDLE);
  assign dbg_state = rst ? 3'd0 : state_q;

endmodule
